act_line_sequencer: RTL and testbench
=====================================

# act_line_sequencer

Sequences one activation (softmax/PWL-activation) layer over the HBM AXI datapath. After a start pulse it fetches the 3-beat activation parameter table, then walks the feature map surface by surface and line by line. For each line it issues one read burst request and one write burst request to the AXI read/write engines. It sits between the CSR block and the activation datapath, and bounds in-flight lines with a credit counter.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of all base/stride/address fields
- DIM_W, 16, width of Win/Hin/CH_div_Tout configuration fields and loop counters
- LEN_W, 16, burst length field width, in beats (one beat = one pixel of Tout channels)
- MAX_OUTSTANDING, 4, maximum lines read-issued but not yet write-completed (1..15)
- PARAM_BEATS, 3, beats in the activation parameter table

Ports:
- clk, in, 1, single clock
- rst, in, 1, asynchronous active-high reset
- start, in, 1, one-cycle launch pulse, honoured only in IDLE
- cfg_wt_base, in, ADDR_W, parameter table byte address
- cfg_in_base / cfg_in_surface_stride / cfg_in_line_stride, in, ADDR_W each, input tensor geometry
- cfg_out_base / cfg_out_surface_stride / cfg_out_line_stride, in, ADDR_W each, output tensor geometry
- cfg_win / cfg_hin / cfg_ch_div_tout, in, DIM_W each, pixels per line / lines per surface / surfaces
- rd_req_valid, out, 1; rd_req_ready, in, 1; rd_req_addr, out, ADDR_W; rd_req_len, out, LEN_W
- rd_req_is_param, out, 1, marks the request as the parameter fetch
- param_beat_valid, in, 1, one parameter beat accepted by the datapath
- wr_req_valid, out, 1; wr_req_ready, in, 1; wr_req_addr, out, ADDR_W; wr_req_len, out, LEN_W
- wr_line_done, in, 1, pulse when the last beat of one output line is written back
- param_loaded, out, 1, level, high from table completion until the next start
- busy, out, 1; done, out, 1 (one-cycle pulse)
- outstanding, out, 4, current credit count

## Operation
- States: IDLE, PARAM_REQ, PARAM_WAIT, RUN, DRAIN, FINISH.
- IDLE: start latches all cfg_* into internal registers and moves to PARAM_REQ. cfg_* are ignored after that.
- PARAM_REQ: rd_req_valid=1, rd_req_is_param=1, addr=wt_base, len=PARAM_BEATS. Leaves to PARAM_WAIT on handshake.
- PARAM_WAIT: counts param_beat_valid. On the PARAM_BEATS-th beat it sets param_loaded=1.
  - If any of win/hin/ch_div_tout is zero, go to FINISH with no line requests.
  - Otherwise go to RUN.
- RUN: two independent line iterators, read (rs, rh) and write (ws, wh), both in surface-major order with h innermost.
  - Read address = in_base + rs*in_surface_stride + rh*in_line_stride.
  - Write address = out_base + ws*out_surface_stride + wh*out_line_stride.
  - Lengths = win.
  - Addresses are computed by accumulation (line_ptr += line_stride; when a surface wraps, surface_ptr += surface_stride and line_ptr = surface_ptr), with no multiplier. Sums are modulo 2^ADDR_W.
  - A read request is presented only while outstanding < MAX_OUTSTANDING and read lines remain.
  - A write request is presented only while write lines issued < read lines issued.
- outstanding +1 on each line read handshake and -1 on each wr_line_done. If both happen in the same cycle, the value is unchanged. wr_line_done at outstanding=0 is ignored.
- When all read and write requests have been issued, go to DRAIN. DRAIN waits for outstanding==0, then goes to FINISH.
- FINISH: done=1 for one cycle, then IDLE. busy=1 in every state except IDLE.
- start outside IDLE is ignored.
- rst mid-operation returns to IDLE immediately, clears all counters, and produces no done.

## Timing
- Reset values: rd_req_valid=0, wr_req_valid=0, rd_req_is_param=0, all address and length outputs 0, param_loaded=0, busy=0, done=0, outstanding=0.
- start at edge N gives busy=1 and rd_req_valid=1 (param) from edge N+1.
- Once valid is asserted, valid/addr/len stay stable until ready. A handshake occurs when valid&&ready are high at a rising edge.
- The next request may be presented in the cycle after a handshake, so a ready held high sustains 1 request per cycle per channel.
- All outputs are registered.
- done is asserted the cycle after DRAIN observes outstanding==0 (registered). param_loaded is asserted the cycle after the last parameter beat.

## Test plan
- Nominal: win=32, hin=1, ch_div=4, in_base=0x0100_0000, in strides 0x800/0x800, out_base=0x0800_0000, ready tied high, wr_line_done 5 cycles after each write handshake.
  - Param read first: 0x0200_0000, len 3.
  - Line reads: 0x0100_0000, 0x0100_0800, 0x0100_1000, 0x0100_1800, each len 32.
  - Writes: the matching 0x0800_xxxx addresses.
  - Single done pulse.
- Credit stall: 8 lines, wr_line_done withheld. Exactly 4 reads issue and rd_req_valid stays low. One wr_line_done releases exactly one more read.
- Backpressure: rd_req_ready low for 10 cycles mid-line. rd_req_addr and rd_req_len hold unchanged; there are no duplicate or skipped addresses.
- Zero dimension: hin=0. Only the param request issues, then done, with zero line requests.
- Simultaneous events: read handshake and wr_line_done in the same cycle at outstanding=2 leave outstanding=2.
- Reset mid-RUN: rst pulsed after 2 lines. All outputs return to reset values and no done is produced. A new start restarts from the param fetch.

Source files
------------

// File: rtl/act_line_sequencer.sv
// Activation-layer line sequencer: fetches the parameter table, then issues one read and one
// write burst request per feature-map line, with in-flight lines bounded by a credit counter.
module act_line_sequencer #(
  parameter int ADDR_W          = 32,
  parameter int DIM_W           = 16,
  parameter int LEN_W           = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PARAM_BEATS     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_wt_base,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_in_surface_stride,
  input  logic [ADDR_W-1:0] cfg_in_line_stride,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [ADDR_W-1:0] cfg_out_surface_stride,
  input  logic [ADDR_W-1:0] cfg_out_line_stride,
  input  logic [DIM_W-1:0]  cfg_win,
  input  logic [DIM_W-1:0]  cfg_hin,
  input  logic [DIM_W-1:0]  cfg_ch_div_tout,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [LEN_W-1:0]  rd_req_len,
  output logic              rd_req_is_param,
  input  logic              param_beat_valid,
  output logic              wr_req_valid,
  input  logic              wr_req_ready,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [LEN_W-1:0]  wr_req_len,
  input  logic              wr_line_done,
  output logic              param_loaded,
  output logic              busy,
  output logic              done,
  output logic [3:0]        outstanding,
  output logic [2:0]        dbg_state
);

  localparam int PEND_W = 2 * DIM_W;
  localparam int PCNT_W = $clog2(PARAM_BEATS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PARAM_REQ, S_PARAM_WAIT, S_RUN, S_DRAIN, S_FINISH
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] in_ss_q, in_ss_d, in_ls_q, in_ls_d, out_ss_q, out_ss_d, out_ls_q, out_ls_d;
  logic [DIM_W-1:0]  win_q, win_d, hin_q, hin_d, chd_q, chd_d;
  logic [DIM_W-1:0]  rd_rs_q, rd_rs_d, rd_rh_q, rd_rh_d, wr_ws_q, wr_ws_d, wr_wh_q, wr_wh_d;
  logic [ADDR_W-1:0] rd_surf_ptr_q, rd_surf_ptr_d, rd_line_ptr_q, rd_line_ptr_d;
  logic [ADDR_W-1:0] wr_surf_ptr_q, wr_surf_ptr_d, wr_line_ptr_q, wr_line_ptr_d;
  logic              rd_all_q, rd_all_d, wr_all_q, wr_all_d;
  logic [PEND_W-1:0] wr_pend_q, wr_pend_d;
  logic [3:0]        outstanding_q, outstanding_d;
  logic [PCNT_W-1:0] param_cnt_q, param_cnt_d;
  logic              param_loaded_q, param_loaded_d, busy_q, busy_d, done_q, done_d;
  logic              rd_req_valid_q, rd_req_valid_d, rd_req_is_param_q, rd_req_is_param_d;
  logic [ADDR_W-1:0] rd_req_addr_q, rd_req_addr_d, wr_req_addr_q, wr_req_addr_d;
  logic [LEN_W-1:0]  rd_req_len_q, rd_req_len_d, wr_req_len_q, wr_req_len_d;
  logic              wr_req_valid_q, wr_req_valid_d;

  // Handshake: a request transfers when valid && ready at a rising edge; once valid is
  // raised, valid/addr/len hold until that transfer.
  logic rd_fire, wr_fire, rd_line_fire, wr_line_fire, done_take;
  assign rd_fire      = rd_req_valid_q && rd_req_ready;
  assign wr_fire      = wr_req_valid_q && wr_req_ready;
  assign rd_line_fire = rd_fire && (state_q == S_RUN);
  assign wr_line_fire = wr_fire && (state_q == S_RUN);
  assign done_take    = wr_line_done && (outstanding_q != 4'd0);

  always_comb begin
    state_d           = state_q;
    in_ss_d           = in_ss_q;
    in_ls_d           = in_ls_q;
    out_ss_d          = out_ss_q;
    out_ls_d          = out_ls_q;
    win_d             = win_q;
    hin_d             = hin_q;
    chd_d             = chd_q;
    rd_rs_d           = rd_rs_q;
    rd_rh_d           = rd_rh_q;
    wr_ws_d           = wr_ws_q;
    wr_wh_d           = wr_wh_q;
    rd_surf_ptr_d     = rd_surf_ptr_q;
    rd_line_ptr_d     = rd_line_ptr_q;
    wr_surf_ptr_d     = wr_surf_ptr_q;
    wr_line_ptr_d     = wr_line_ptr_q;
    rd_all_d          = rd_all_q;
    wr_all_d          = wr_all_q;
    wr_pend_d         = wr_pend_q;
    param_cnt_d       = param_cnt_q;
    param_loaded_d    = param_loaded_q;
    rd_req_valid_d    = rd_req_valid_q;
    rd_req_is_param_d = rd_req_is_param_q;
    rd_req_addr_d     = rd_req_addr_q;
    rd_req_len_d      = rd_req_len_q;
    wr_req_valid_d    = wr_req_valid_q;
    wr_req_addr_d     = wr_req_addr_q;
    wr_req_len_d      = wr_req_len_q;
    outstanding_d     = outstanding_q + 4'(rd_line_fire) - 4'(done_take);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_PARAM_REQ;
          in_ss_d        = cfg_in_surface_stride;
          in_ls_d        = cfg_in_line_stride;
          out_ss_d       = cfg_out_surface_stride;
          out_ls_d       = cfg_out_line_stride;
          win_d          = cfg_win;
          hin_d          = cfg_hin;
          chd_d          = cfg_ch_div_tout;
          rd_rs_d        = '0;
          rd_rh_d        = '0;
          wr_ws_d        = '0;
          wr_wh_d        = '0;
          rd_surf_ptr_d  = cfg_in_base;
          rd_line_ptr_d  = cfg_in_base;
          wr_surf_ptr_d  = cfg_out_base;
          wr_line_ptr_d  = cfg_out_base;
          rd_all_d       = 1'b0;
          wr_all_d       = 1'b0;
          wr_pend_d      = '0;
          param_cnt_d    = '0;
          param_loaded_d = 1'b0;
          outstanding_d  = 4'd0;
        end
      end
      S_PARAM_REQ: begin
        if (rd_fire) state_d = S_PARAM_WAIT;
      end
      S_PARAM_WAIT: begin
        if (param_beat_valid) begin
          if (param_cnt_q == PCNT_W'(PARAM_BEATS - 1)) begin
            param_loaded_d = 1'b1;
            if (win_q == '0 || hin_q == '0 || chd_q == '0) state_d = S_FINISH;
            else state_d = S_RUN;
          end else begin
            param_cnt_d = param_cnt_q + PCNT_W'(1);
          end
        end
      end
      S_RUN: begin
        // Pointers always hold the address of the next line to present; a surface wrap
        // restarts the line pointer from the freshly advanced surface pointer.
        if (rd_line_fire) begin
          if (rd_rh_q == hin_q - DIM_W'(1)) begin
            rd_rh_d       = '0;
            rd_surf_ptr_d = rd_surf_ptr_q + in_ss_q;
            rd_line_ptr_d = rd_surf_ptr_d;
            if (rd_rs_q == chd_q - DIM_W'(1)) rd_all_d = 1'b1;
            else rd_rs_d = rd_rs_q + DIM_W'(1);
          end else begin
            rd_rh_d       = rd_rh_q + DIM_W'(1);
            rd_line_ptr_d = rd_line_ptr_q + in_ls_q;
          end
        end
        if (wr_line_fire) begin
          if (wr_wh_q == hin_q - DIM_W'(1)) begin
            wr_wh_d       = '0;
            wr_surf_ptr_d = wr_surf_ptr_q + out_ss_q;
            wr_line_ptr_d = wr_surf_ptr_d;
            if (wr_ws_q == chd_q - DIM_W'(1)) wr_all_d = 1'b1;
            else wr_ws_d = wr_ws_q + DIM_W'(1);
          end else begin
            wr_wh_d       = wr_wh_q + DIM_W'(1);
            wr_line_ptr_d = wr_line_ptr_q + out_ls_q;
          end
        end
        wr_pend_d = wr_pend_q + PEND_W'(rd_line_fire) - PEND_W'(wr_line_fire);
        if (rd_all_d && wr_all_d) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outstanding_q == 4'd0) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Request registers load from next-cycle state so every output stays a flop.
    if (!(rd_req_valid_q && !rd_req_ready)) begin
      rd_req_valid_d    = 1'b0;
      rd_req_is_param_d = 1'b0;
      if (state_q == S_IDLE && start) begin
        rd_req_valid_d    = 1'b1;
        rd_req_is_param_d = 1'b1;
        rd_req_addr_d     = cfg_wt_base;
        rd_req_len_d      = LEN_W'(PARAM_BEATS);
      end else if (state_d == S_RUN && !rd_all_d &&
                   outstanding_d < 4'(MAX_OUTSTANDING)) begin
        rd_req_valid_d = 1'b1;
        rd_req_addr_d  = rd_line_ptr_d;
        rd_req_len_d   = LEN_W'(win_q);
      end
    end
    if (!(wr_req_valid_q && !wr_req_ready)) begin
      wr_req_valid_d = 1'b0;
      if (state_d == S_RUN && !wr_all_d && wr_pend_d != '0) begin
        wr_req_valid_d = 1'b1;
        wr_req_addr_d  = wr_line_ptr_d;
        wr_req_len_d   = LEN_W'(win_q);
      end
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      in_ss_q           <= '0;
      in_ls_q           <= '0;
      out_ss_q          <= '0;
      out_ls_q          <= '0;
      win_q             <= '0;
      hin_q             <= '0;
      chd_q             <= '0;
      rd_rs_q           <= '0;
      rd_rh_q           <= '0;
      wr_ws_q           <= '0;
      wr_wh_q           <= '0;
      rd_surf_ptr_q     <= '0;
      rd_line_ptr_q     <= '0;
      wr_surf_ptr_q     <= '0;
      wr_line_ptr_q     <= '0;
      rd_all_q          <= 1'b0;
      wr_all_q          <= 1'b0;
      wr_pend_q         <= '0;
      outstanding_q     <= '0;
      param_cnt_q       <= '0;
      param_loaded_q    <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      rd_req_valid_q    <= 1'b0;
      rd_req_is_param_q <= 1'b0;
      rd_req_addr_q     <= '0;
      rd_req_len_q      <= '0;
      wr_req_valid_q    <= 1'b0;
      wr_req_addr_q     <= '0;
      wr_req_len_q      <= '0;
    end else begin
      state_q           <= state_d;
      in_ss_q           <= in_ss_d;
      in_ls_q           <= in_ls_d;
      out_ss_q          <= out_ss_d;
      out_ls_q          <= out_ls_d;
      win_q             <= win_d;
      hin_q             <= hin_d;
      chd_q             <= chd_d;
      rd_rs_q           <= rd_rs_d;
      rd_rh_q           <= rd_rh_d;
      wr_ws_q           <= wr_ws_d;
      wr_wh_q           <= wr_wh_d;
      rd_surf_ptr_q     <= rd_surf_ptr_d;
      rd_line_ptr_q     <= rd_line_ptr_d;
      wr_surf_ptr_q     <= wr_surf_ptr_d;
      wr_line_ptr_q     <= wr_line_ptr_d;
      rd_all_q          <= rd_all_d;
      wr_all_q          <= wr_all_d;
      wr_pend_q         <= wr_pend_d;
      outstanding_q     <= outstanding_d;
      param_cnt_q       <= param_cnt_d;
      param_loaded_q    <= param_loaded_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      rd_req_valid_q    <= rd_req_valid_d;
      rd_req_is_param_q <= rd_req_is_param_d;
      rd_req_addr_q     <= rd_req_addr_d;
      rd_req_len_q      <= rd_req_len_d;
      wr_req_valid_q    <= wr_req_valid_d;
      wr_req_addr_q     <= wr_req_addr_d;
      wr_req_len_q      <= wr_req_len_d;
    end
  end

  assign rd_req_valid    = rd_req_valid_q;
  assign rd_req_is_param = rd_req_is_param_q;
  assign rd_req_addr     = rd_req_addr_q;
  assign rd_req_len      = rd_req_len_q;
  assign wr_req_valid    = wr_req_valid_q;
  assign wr_req_addr     = wr_req_addr_q;
  assign wr_req_len      = wr_req_len_q;
  assign param_loaded    = param_loaded_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign outstanding     = outstanding_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_act_line_sequencer.sv
// Bench for act_line_sequencer: expected requests are queued at job launch and popped on
// each handshake; a credit model tracks outstanding every cycle.
module tb_act_line_sequencer;
  localparam int ADDR_W = 32;
  localparam int DIM_W  = 16;
  localparam int LEN_W  = 16;
  localparam int MAXO   = 4;
  localparam int PB     = 3;

  logic              clk, rst, start;
  logic [ADDR_W-1:0] cfg_wt_base, cfg_in_base, cfg_in_surface_stride, cfg_in_line_stride;
  logic [ADDR_W-1:0] cfg_out_base, cfg_out_surface_stride, cfg_out_line_stride;
  logic [DIM_W-1:0]  cfg_win, cfg_hin, cfg_ch_div_tout;
  logic              rd_req_valid, rd_req_ready, rd_req_is_param, param_beat_valid;
  logic [ADDR_W-1:0] rd_req_addr, wr_req_addr;
  logic [LEN_W-1:0]  rd_req_len, wr_req_len;
  logic              wr_req_valid, wr_req_ready, wr_line_done;
  logic              param_loaded, busy, done;
  logic [3:0]        outstanding;
  logic [2:0]        dbg_state;

  act_line_sequencer #(
    .ADDR_W(ADDR_W), .DIM_W(DIM_W), .LEN_W(LEN_W),
    .MAX_OUTSTANDING(MAXO), .PARAM_BEATS(PB)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_wt_base(cfg_wt_base), .cfg_in_base(cfg_in_base),
    .cfg_in_surface_stride(cfg_in_surface_stride), .cfg_in_line_stride(cfg_in_line_stride),
    .cfg_out_base(cfg_out_base), .cfg_out_surface_stride(cfg_out_surface_stride),
    .cfg_out_line_stride(cfg_out_line_stride),
    .cfg_win(cfg_win), .cfg_hin(cfg_hin), .cfg_ch_div_tout(cfg_ch_div_tout),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_len(rd_req_len), .rd_req_is_param(rd_req_is_param),
    .param_beat_valid(param_beat_valid),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_len(wr_req_len), .wr_line_done(wr_line_done),
    .param_loaded(param_loaded), .busy(busy), .done(done),
    .outstanding(outstanding), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard state
  logic [63:0] rd_exp_q[$];
  logic [63:0] wr_exp_q[$];
  int          due_q[$];
  int          cycle = 0;
  int          param_pend = 0;
  int          exp_out = 0;
  int          rd_line_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int          release_cnt = 0;
  bit          rd_block = 0, withhold = 0, prev_rd_stall = 0;
  logic [63:0] saved_rd;

  function automatic logic [63:0] pack_req(input logic p, input logic [LEN_W-1:0] len,
                                           input logic [ADDR_W-1:0] a);
    return {15'b0, p, len, a};
  endfunction

  // One cycle: observe outputs of the last rising edge, drive inputs for the next one,
  // and score the handshakes that edge will perform.
  task automatic step();
    bit dec;
    @(negedge clk);
    cycle++;
    if (rst) begin
      exp_out = 0; param_pend = 0; prev_rd_stall = 0;
      due_q.delete(); rd_exp_q.delete(); wr_exp_q.delete();
      rd_req_ready = 1'b0; wr_req_ready = 1'b0; param_beat_valid = 1'b0; wr_line_done = 1'b0;
      return;
    end
    check_eq("outstanding", 64'(outstanding), 64'(exp_out));
    if (done) done_cnt++;
    if (prev_rd_stall) begin
      check_eq("rd_hold_valid", 64'(rd_req_valid), 64'd1);
      check_eq("rd_hold_req", pack_req(rd_req_is_param, rd_req_len, rd_req_addr), saved_rd);
    end
    rd_req_ready = !rd_block;
    wr_req_ready = 1'b1;
    param_beat_valid = (param_pend > 0);
    if (param_pend > 0) param_pend--;
    wr_line_done = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cycle && (!withhold || release_cnt > 0)) begin
      wr_line_done = 1'b1;
      void'(due_q.pop_front());
      if (withhold) release_cnt--;
    end
    dec = wr_line_done && (exp_out != 0);
    if (rd_req_valid && rd_req_ready) begin
      if (rd_exp_q.size() == 0) check_eq("rd_unexpected", 64'(rd_exp_q.size()), 64'd1);
      else check_eq("rd_req", pack_req(rd_req_is_param, rd_req_len, rd_req_addr),
                    rd_exp_q.pop_front());
      if (rd_req_is_param) param_pend = PB;
      else begin
        rd_line_cnt++;
        exp_out++;
      end
    end
    if (wr_req_valid && wr_req_ready) begin
      if (wr_exp_q.size() == 0) check_eq("wr_unexpected", 64'(wr_exp_q.size()), 64'd1);
      else check_eq("wr_req", pack_req(1'b0, wr_req_len, wr_req_addr), wr_exp_q.pop_front());
      wr_cnt++;
      due_q.push_back(cycle + 5);
    end
    if (dec) exp_out--;
    prev_rd_stall = rd_req_valid && !rd_req_ready;
    saved_rd = pack_req(rd_req_is_param, rd_req_len, rd_req_addr);
  endtask

  // driver tasks
  task automatic push_job(input logic [31:0] wt, inb, iss, ils, outb, oss, ols,
                          input int win, hin, chd);
    cfg_wt_base = wt; cfg_in_base = inb; cfg_in_surface_stride = iss; cfg_in_line_stride = ils;
    cfg_out_base = outb; cfg_out_surface_stride = oss; cfg_out_line_stride = ols;
    cfg_win = DIM_W'(win); cfg_hin = DIM_W'(hin); cfg_ch_div_tout = DIM_W'(chd);
    rd_exp_q.push_back(pack_req(1'b1, LEN_W'(PB), wt));
    if (win != 0) begin
      for (int s = 0; s < chd; s++)
        for (int h = 0; h < hin; h++) begin
          rd_exp_q.push_back(pack_req(1'b0, LEN_W'(win), inb + s * iss + h * ils));
          wr_exp_q.push_back(pack_req(1'b0, LEN_W'(win), outb + s * oss + h * ols));
        end
    end
    rd_line_cnt = 0; wr_cnt = 0; done_cnt = 0; release_cnt = 0;
  endtask

  task automatic start_job();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_busy", 64'(busy), 64'd1);
    check_eq("start_rd_valid", 64'(rd_req_valid), 64'd1);
    check_eq("start_is_param", 64'(rd_req_is_param), 64'd1);
    check_eq("start_param_loaded", 64'(param_loaded), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    for (int i = 0; i < 2000 && done_cnt == d0; i++) step();
    repeat (5) step();
    check_eq({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check_eq({tag, "_rd_left"}, 64'(rd_exp_q.size()), 64'd0);
    check_eq({tag, "_wr_left"}, 64'(wr_exp_q.size()), 64'd0);
    check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
    check_eq({tag, "_param_loaded"}, 64'(param_loaded), 64'd1);
  endtask

  task automatic wait_reads(input int n);
    for (int i = 0; i < 300 && rd_line_cnt < n; i++) step();
    check_eq("reads_reached", 64'(rd_line_cnt), 64'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_valid"}, 64'(rd_req_valid), 64'd0);
    check_eq({tag, "_wr_valid"}, 64'(wr_req_valid), 64'd0);
    check_eq({tag, "_is_param"}, 64'(rd_req_is_param), 64'd0);
    check_eq({tag, "_rd_addr_len"}, {rd_req_len, rd_req_addr}, 64'd0);
    check_eq({tag, "_wr_addr_len"}, {wr_req_len, wr_req_addr}, 64'd0);
    check_eq({tag, "_param_loaded"}, 64'(param_loaded), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_outstanding"}, 64'(outstanding), 64'd0);
    check_eq({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    rd_req_ready = 1'b0; wr_req_ready = 1'b0; param_beat_valid = 1'b0; wr_line_done = 1'b0;
    cfg_wt_base = '0; cfg_in_base = '0; cfg_in_surface_stride = '0; cfg_in_line_stride = '0;
    cfg_out_base = '0; cfg_out_surface_stride = '0; cfg_out_line_stride = '0;
    cfg_win = '0; cfg_hin = '0; cfg_ch_div_tout = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_reset_outputs("reset");

    // nominal 4-line job
    push_job(32'h0200_0000, 32'h0100_0000, 32'h800, 32'h800,
             32'h0800_0000, 32'h800, 32'h800, 32, 1, 4);
    start_job();
    wait_done("nominal");
    check_eq("nominal_reads", 64'(rd_line_cnt), 64'd4);
    check_eq("nominal_writes", 64'(wr_cnt), 64'd4);

    // credit stall: completions withheld
    withhold = 1;
    push_job(32'h300, 32'h1000, 32'h10000, 32'h40, 32'h2000_0000, 32'h10000, 32'h80, 8, 8, 1);
    start_job();
    repeat (40) step();
    check_eq("stall_reads", 64'(rd_line_cnt), 64'(MAXO));
    check_eq("stall_rd_valid", 64'(rd_req_valid), 64'd0);
    check_eq("stall_writes", 64'(wr_cnt), 64'(MAXO));
    release_cnt = 1;
    repeat (10) step();
    check_eq("stall_one_more", 64'(rd_line_cnt), 64'(MAXO + 1));
    check_eq("stall_rd_valid2", 64'(rd_req_valid), 64'd0);
    withhold = 0;
    wait_done("stall");

    // read backpressure mid-job
    push_job(32'h400, 32'h4000_0000, 32'h2000, 32'h100,
             32'h5000_0000, 32'h3000, 32'h200, 16, 3, 2);
    start_job();
    wait_reads(2);
    rd_block = 1;
    repeat (10) step();
    check_eq("bp_valid_held", 64'(rd_req_valid), 64'd1);
    check_eq("bp_reads_frozen", 64'(rd_line_cnt), 64'd2);
    rd_block = 0;
    wait_done("bp");

    // zero dimension
    push_job(32'h500, 32'h6000, 32'h100, 32'h10, 32'h7000, 32'h100, 32'h10, 8, 0, 2);
    start_job();
    wait_done("zero");
    check_eq("zero_reads", 64'(rd_line_cnt), 64'd0);
    check_eq("zero_writes", 64'(wr_cnt), 64'd0);

    // simultaneous read handshake and line completion at outstanding=2
    withhold = 1;
    push_job(32'h600, 32'h8000, 32'h1000, 32'h100, 32'h9000, 32'h1000, 32'h100, 4, 4, 2);
    start_job();
    wait_reads(2);
    rd_block = 1;
    repeat (10) step();
    check_eq("simul_pre_out", 64'(outstanding), 64'd2);
    rd_block = 0;
    release_cnt = 1;
    step();
    check_eq("simul_both", 64'({rd_line_cnt == 3, wr_line_done}), 64'd3);
    step();
    check_eq("simul_outstanding", 64'(outstanding), 64'd2);
    withhold = 0;
    wait_done("simul");

    // reset in the middle of RUN, then a fresh job
    push_job(32'h700, 32'hA000, 32'h1000, 32'h100, 32'hB000, 32'h1000, 32'h100, 8, 2, 2);
    start_job();
    wait_reads(2);
    rst = 1'b1;
    step();
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (10) step();
    check_eq("midrst_no_done", 64'(done_cnt), 64'd0);
    check_eq("midrst_idle", 64'(busy), 64'd0);
    push_job(32'h0200_0000, 32'h0100_0000, 32'h800, 32'h800,
             32'h0800_0000, 32'h800, 32'h800, 32, 1, 4);
    start_job();
    wait_done("restart");
    check_eq("restart_reads", 64'(rd_line_cnt), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
